// File: rtl/conv_window_buffer.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_buffer
// Brief   : Sliding row window feeding the conv layer (valid/ready, stride, seq end)
// Revision: 1.0 - initial release
// ============================================================================
module conv_window_buffer #(
    parameter int INPUT_LAYER_HEIGHT = 4,
    parameter int KERNEL_WIDTH       = 2,
    parameter int WORD_SIZE          = 16,
    parameter int STRIDE             = 1
) (
    input  logic                                                         clk_i,
    input  logic                                                         reset_i,
    input  logic                                                         valid_i,
    output logic                                                         ready_o,
    input  logic [KERNEL_WIDTH-1:0][WORD_SIZE-1:0]                       data_i,
    input  logic                                                         last_i,
    input  logic                                                         flush_i,
    output logic                                                         valid_o,
    input  logic                                                         ready_i,
    output logic [INPUT_LAYER_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] data_o,
    output logic                                                         last_o
);

    localparam int c_CNT_W = $clog2(INPUT_LAYER_HEIGHT + 1);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(INPUT_LAYER_HEIGHT);
    localparam logic [c_CNT_W-1:0] c_STRIDE = c_CNT_W'(STRIDE);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    generate
        if (INPUT_LAYER_HEIGHT < 1 || STRIDE < 1 || STRIDE > INPUT_LAYER_HEIGHT) begin : g_bad_cfg
            $error("conv_window_buffer: need INPUT_LAYER_HEIGHT >= 1 and 1 <= STRIDE <= INPUT_LAYER_HEIGHT");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                                                         r_state;
    logic [c_CNT_W-1:0]                                             r_rows_needed;
    logic                                                           r_seq_last;
    logic                                                           r_last;
    logic [INPUT_LAYER_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] r_data;

    logic w_last_acc;
    logic w_completes;

    assign w_last_acc  = r_seq_last | last_i;
    assign w_completes = (r_rows_needed == c_ONE);

    assign ready_o = (r_state != S_HOLD);
    assign valid_o = (r_state == S_HOLD);
    assign last_o  = r_last;
    assign data_o  = r_data;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_state       <= S_FILL;
            r_rows_needed <= c_FULL;
            r_seq_last    <= 1'b0;
            r_last        <= 1'b0;
            r_data        <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (valid_i) begin
                        // Oldest row sits at index 0 and falls off the end.
                        for (int k = 0; k < INPUT_LAYER_HEIGHT - 1; k++) begin
                            r_data[k] <= r_data[k+1];
                        end
                        r_data[INPUT_LAYER_HEIGHT-1] <= data_i;
                        if (w_completes) begin
                            r_state       <= S_HOLD;
                            r_rows_needed <= '0;
                            r_seq_last    <= w_last_acc;
                            r_last        <= w_last_acc;
                        end else if (last_i) begin
                            // Short sequence: drop the partial window, keep the stale rows.
                            r_rows_needed <= c_FULL;
                            r_seq_last    <= 1'b0;
                        end else begin
                            r_rows_needed <= r_rows_needed - c_ONE;
                            r_seq_last    <= w_last_acc;
                        end
                    end
                end
                S_HOLD: begin
                    if (ready_i) begin
                        r_state       <= S_FILL;
                        r_rows_needed <= r_seq_last ? c_FULL : c_STRIDE;
                        r_seq_last    <= 1'b0;
                        r_last        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
